// File: rtl/bitwise_shift_logic_unit.sv
// WIDTH-bit logic unit: single-edge bitwise ops plus a serial shift/rotate engine that moves one bit per clock.
// The result and flags registers drive shared buses only while oe is high.
module bitwise_shift_logic_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             oe,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] primary_operand,
    input  logic [WIDTH-1:0] secondary_operand,
    input  logic [AMT_W-1:0] shift_amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int LOG_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOTA = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_PASB = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   result_reg;
    logic [3:0]         flags_reg;
    logic [WIDTH-1:0]   work;
    logic [AMT_W-1:0]   count;
    logic [3:0]         shift_op;
    logic               is_shift;
    logic               is_rotate;
    logic [AMT_W-1:0]   eff_amt;
    logic [WIDTH:0]     step;

    // Everything that is not a shift with a non-zero count (including the
    // reserved codes and zero-length shifts) resolves here; the default is A.
    function automatic logic [WIDTH-1:0] logic_result(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            OP_AND:  logic_result = a & b;
            OP_OR:   logic_result = a | b;
            OP_XOR:  logic_result = a ^ b;
            OP_NOTA: logic_result = ~a;
            OP_NAND: logic_result = ~(a & b);
            OP_NOR:  logic_result = ~(a | b);
            OP_XNOR: logic_result = ~(a ^ b);
            OP_PASB: logic_result = b;
            default: logic_result = a;
        endcase
    endfunction

    // Packed as {P, C, N, Z}.
    function automatic logic [3:0] flag_bits(
        input logic [WIDTH-1:0] r,
        input logic             c
    );
        flag_bits = {^r, c, r[WIDTH-1], (r == '0)};
    endfunction

    // One-bit move of the work register; the MSB of the return is the bit
    // that left the register, the rest is the new work value.
    function automatic logic [WIDTH:0] shift_step(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] w
    );
        case (op)
            OP_SLL:  shift_step = {w, 1'b0};
            OP_SRL:  shift_step = {w[0], 1'b0, w[WIDTH-1:1]};
            OP_SRA:  shift_step = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
            OP_ROL:  shift_step = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
            default: shift_step = {w[0], w[0], w[WIDTH-1:1]};
        endcase
    endfunction

    assign is_shift  = (opcode >= OP_SLL) && (opcode <= OP_ROR);
    assign is_rotate = (opcode == OP_ROL) || (opcode == OP_ROR);

    // Linear shifts saturate at WIDTH (everything shifted out); rotates
    // only care about the count modulo WIDTH.
    always_comb begin
        eff_amt = '0;
        if (is_rotate) begin
            eff_amt = AMT_W'(shift_amount[LOG_W-1:0]);
        end else if (shift_amount > AMT_W'(WIDTH)) begin
            eff_amt = AMT_W'(WIDTH);
        end else begin
            eff_amt = shift_amount;
        end
    end

    assign step = shift_step(shift_op, work);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_shift && (eff_amt != '0)) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == AMT_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            result_reg <= '0;
            flags_reg  <= '0;
            work       <= '0;
            count      <= '0;
            shift_op   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= primary_operand;
                        count    <= eff_amt;
                        shift_op <= opcode;
                        if (!(is_shift && (eff_amt != '0))) begin
                            result_reg <= logic_result(opcode, primary_operand, secondary_operand);
                            flags_reg  <= flag_bits(logic_result(opcode, primary_operand,
                                                                 secondary_operand), 1'b0);
                            done       <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step[WIDTH-1:0];
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        result_reg <= step[WIDTH-1:0];
                        flags_reg  <= flag_bits(step[WIDTH-1:0], step[WIDTH]);
                        done       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = oe ? result_reg : {WIDTH{1'bz}};
    assign flags  = oe ? flags_reg  : 4'bzzzz;

endmodule

// File: tb/tb_bitwise_shift_logic_unit.sv
// Scoreboard bench for bitwise_shift_logic_unit: stimulus pushes expected completions,
// a negedge monitor pops them whenever done is seen.
module tb_bitwise_shift_logic_unit;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       oe = 1'b1;
    logic       start = 1'b0;
    logic [3:0] opcode = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] amt = '0;
    wire        busy;
    wire        done;
    wire  [7:0] result;
    wire  [3:0] flags;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic       hz;
        int         when;
        int         n;
    } exp_t;
    exp_t sb[$];

    bitwise_shift_logic_unit #(.WIDTH(8), .AMT_W(4)) dut (
        .clock(clock), .nreset(nreset), .oe(oe), .start(start), .opcode(opcode),
        .primary_operand(a), .secondary_operand(b), .shift_amount(amt),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A two-state simulator resolves an undriven bus to a constant, so an
    // all-z bus or any value other than the one that would be driven passes.
    task automatic check_hz(input string name, input logic [7:0] act, input logic [7:0] driven);
        compared++;
        if (!((act === 8'hzz) || (act !== driven))) begin
            mismatched++;
            $display("FAIL %s: got %0h while oe=0, expected high-Z", name, act);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!nreset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    if (e.hz) begin
                        check_hz("result_hz", result, e.res);
                        check_hz("flags_hz", {4'h0, flags}, {4'h0, e.flg});
                    end else begin
                        check("result", 32'(result), 32'(e.res));
                        check("flags", 32'(flags), 32'(e.flg));
                    end
                    check("done_cycle", 32'(cyc), 32'(e.when));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.n));
                    check("busy_with_done", 32'(busy), 32'(0));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] pa, input logic [7:0] pb,
                         input logic [3:0] sa, input logic [7:0] er, input logic [3:0] ef,
                         input int n, input logic hz);
        exp_t e;
        @(negedge clock);
        opcode = op; a = pa; b = pb; amt = sa; start = 1'b1;
        e.res = er; e.flg = ef; e.hz = hz; e.when = cyc + 1 + n; e.n = n;
        sb.push_back(e);
    endtask

    task automatic drain();
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
        check("drain_pending", 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_result", 32'(result), 32'(0));
        check("reset_flags", 32'(flags), 32'(0));
        nreset = 1'b1;

        // flags are {P, C, N, Z}
        issue(4'd0, 8'hF0, 8'h3C, 4'd0, 8'h30, 4'b0000, 0, 1'b0); drain();
        issue(4'd8, 8'h81, 8'h00, 4'd1, 8'h02, 4'b1100, 1, 1'b0); drain();
        issue(4'd10, 8'h80, 8'h00, 4'd3, 8'hF0, 4'b0010, 3, 1'b0); drain();
        issue(4'd9, 8'hFF, 8'h00, 4'd12, 8'h00, 4'b0101, 8, 1'b0); drain();
        issue(4'd12, 8'h01, 8'h00, 4'd9, 8'h80, 4'b1110, 1, 1'b0); drain();
        issue(4'd11, 8'h5A, 8'h00, 4'd8, 8'h5A, 4'b0000, 0, 1'b0); drain();
        issue(4'd1, 8'hF0, 8'h0C, 4'd0, 8'hFC, 4'b0010, 0, 1'b0); drain();
        issue(4'd3, 8'h0F, 8'h00, 4'd0, 8'hF0, 4'b0010, 0, 1'b0); drain();
        issue(4'd4, 8'hF0, 8'h3C, 4'd0, 8'hCF, 4'b0010, 0, 1'b0); drain();
        issue(4'd5, 8'hF0, 8'h0F, 4'd0, 8'h00, 4'b0001, 0, 1'b0); drain();
        issue(4'd7, 8'h99, 8'h07, 4'd0, 8'h07, 4'b1000, 0, 1'b0); drain();
        issue(4'd13, 8'h80, 8'h11, 4'd0, 8'h80, 4'b1010, 0, 1'b0); drain();
        issue(4'd8, 8'h01, 8'h00, 4'd8, 8'h00, 4'b0101, 8, 1'b0); drain();
        issue(4'd11, 8'h81, 8'h00, 4'd1, 8'h03, 4'b0100, 1, 1'b0); drain();
        issue(4'd10, 8'h7F, 8'h00, 4'd15, 8'h00, 4'b0001, 8, 1'b0); drain();

        // back-to-back: second start lands in the done cycle of the first
        issue(4'd0, 8'hFF, 8'h0F, 4'd0, 8'h0F, 4'b0000, 0, 1'b0);
        issue(4'd2, 8'hFF, 8'h01, 4'd0, 8'hFE, 4'b1010, 0, 1'b0); drain();

        // start while busy must not disturb the running shift
        issue(4'd10, 8'h80, 8'h00, 4'd3, 8'hF0, 4'b0010, 3, 1'b0);
        @(negedge clock);
        opcode = 4'd0; a = 8'h00; b = 8'h00; amt = 4'd0; start = 1'b1;
        drain();

        issue(4'd6, 8'hA5, 8'hA4, 4'd0, 8'hFE, 4'b1010, 0, 1'b0); drain();

        // reset in the middle of a shift abandons it without a done pulse
        @(negedge clock);
        opcode = 4'd8; a = 8'h01; amt = 4'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        opcode = 4'd1; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clock);
        start = 1'b0; nreset = 1'b0;
        @(negedge clock);
        check("midreset_busy", 32'(busy), 32'(0));
        check("midreset_done", 32'(done), 32'(0));
        check("midreset_result", 32'(result), 32'(0));
        check("midreset_flags", 32'(flags), 32'(0));
        @(negedge clock);
        nreset = 1'b1;
        repeat (12) @(negedge clock);

        // oe low: buses float, handshake still runs
        oe = 1'b0;
        issue(4'd2, 8'hAA, 8'h55, 4'd0, 8'hFF, 4'b0010, 0, 1'b1); drain();
        @(negedge clock);
        oe = 1'b1;
        #1;
        check("oe_result", 32'(result), 32'(8'hFF));
        check("oe_flags", 32'(flags), 32'(4'b0010));

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bitwise_shift_logic_unit.md
Name: bitwise_shift_logic_unit

Overview:
- Parametrised successor to the 8-bit AND/OR logic unit: WIDTH-bit datapath, full bitwise opcode set plus serial (one bit per cycle) shift/rotate engine.
- Start/busy/done handshake; registered result and flags; both driven onto shared buses only while oe is high.
- Sits beside the adder on the datapath result/flag buses; the control sequencer issues start and waits on done.

Parameters:
- WIDTH, 8, datapath width; power of two, >= 4.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount input.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- nreset  in  1  synchronous, active-low reset.
- oe  in  1  output enable; result/flags high-Z when 0.
- start  in  1  request; sampled only in IDLE.
- opcode  in  4  operation select, latched with start.
- primary_operand  in  WIDTH  operand A, latched with start.
- secondary_operand  in  WIDTH  operand B, latched with start.
- shift_amount  in  AMT_W  shift/rotate count, latched with start.
- busy  out  1  high while in SHIFT state.
- done  out  1  one-cycle pulse when result/flags are updated.
- result  out  WIDTH  registered result; high-Z when oe=0.
- flags  out  4  [0]=Z, [1]=N, [2]=C, [3]=P; high-Z when oe=0.

Behaviour:
- Reset (nreset=0 at an edge): state IDLE, busy=0, done=0, result reg=0, flags reg=0, work reg=0, count=0. This applies mid-shift: the operation is abandoned and no done is issued.
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 NAND, 5 NOR, 6 XNOR, 7 PASS B, 8 SLL, 9 SRL, 10 SRA, 11 ROL, 12 ROR, 13-15 reserved (PASS A).
- States: IDLE, SHIFT.
- Logic, PASS and reserved ops:
  - At the edge where start=1 is sampled in IDLE, result and flags are written.
  - done=1 for the following cycle; state stays IDLE.
  - Latency is 1 edge; C=0.
- Shift ops, load edge:
  - At the start edge, the work reg loads A, C_work=0, and count is set to the effective amount n.
  - SLL/SRL/SRA: n = min(shift_amount, WIDTH).
  - ROL/ROR: n = shift_amount mod WIDTH (low $clog2(WIDTH) bits).
  - n=0: behaves as a logic op (result=A, C=0, done after 1 edge, busy never asserted).
  - n>0: go to SHIFT; busy=1.
- SHIFT state, per edge:
  - The work reg moves one bit and count decrements.
  - C_work = the bit shifted or rotated out.
  - SLL fills with 0. SRL fills with 0. SRA fills with the sign bit. Rotates wrap the bit out.
  - On the edge where count reaches 0: write result=work, write flags, state=IDLE, busy=0, done=1 the next cycle.
  - Total latency is n+1 edges; busy is high for n cycles.
- Result and flags registers are not modified during SHIFT. They stay stable from done until the next completion.
- Flags are computed from the final result value:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C = last bit out (0 for non-shift ops).
  - P = XOR of all result bits (1 = odd number of ones).
- start while busy is ignored; operands are not re-latched.
- start in the done cycle is accepted, because the state is IDLE.
- done is never asserted together with busy.
- oe affects only the output drivers. Internal state and the handshake run regardless of oe; busy and done are never tri-stated.

Test Plan:
- Reset, then start AND with A=0xF0, B=0x3C, oe=1 -> after 1 edge result=0x30, flags Z0 N0 C0 P0, done high 1 cycle, busy never high.
- SLL with A=0x81, amount=1 -> busy 1 cycle, done after edge 2, result=0x02, C=1, Z=0, P=1.
- SRA with A=0x80, amount=3 -> busy 3 cycles, result=0xF0, N=1, C=0, P=0. Separately, SRL with A=0xFF, amount=12 -> clamped to 8, 9-edge latency, result=0x00, Z=1, C=1.
- ROR with A=0x01, amount=9 -> effective 1, result=0x80, C=1, N=1. Separately, ROL with amount=8 -> effective 0, result=A, 1-edge latency.
- Start SLL amount=5, then assert start with new operands at cycle 2 (ignored), then nreset=0 at cycle 3 -> busy=0, done=0, result=0, flags=0, no done pulse ever.
- XOR with A=0xAA, B=0x55 and oe=0 -> result and flags high-Z, done still pulses. Raise oe afterwards -> result=0xFF, N=1, P=0.
